// File: rtl/shift_reg_pkg.sv
// Shared encodings for the universal shift register: command opcodes and FSM states.
package shift_reg_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_LOAD = 3'b001,
      OP_DUMP = 3'b010,
      OP_SHR  = 3'b011,
      OP_SAR  = 3'b100,
      OP_SHL  = 3'b101,
      OP_ROR  = 3'b110,
      OP_ROL  = 3'b111
   } op_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   function automatic logic is_shift_op(input op_t o);
      return (o == OP_SHR) || (o == OP_SAR) || (o == OP_SHL) ||
             (o == OP_ROR) || (o == OP_ROL);
   endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step: next storage value and the bit that leaves the register.
module shift_step
   import shift_reg_pkg::*;
#(
   parameter int REG_WIDTH = 8
) (
   input  logic [REG_WIDTH-1:0] s,
   input  op_t                  op,
   input  logic                 shiftin,
   output logic [REG_WIDTH-1:0] next,
   output logic                 out_bit
);

   always_comb begin
      next    = s;
      out_bit = 1'b0;
      case (op)
         OP_SHR: begin
            next    = {shiftin, s[REG_WIDTH-1:1]};
            out_bit = s[0];
         end
         OP_SAR: begin
            next    = {s[REG_WIDTH-1], s[REG_WIDTH-1:1]};
            out_bit = s[0];
         end
         OP_SHL: begin
            next    = {s[REG_WIDTH-2:0], shiftin};
            out_bit = s[REG_WIDTH-1];
         end
         OP_ROR: begin
            next    = {s[0], s[REG_WIDTH-1:1]};
            out_bit = s[0];
         end
         OP_ROL: begin
            next    = {s[REG_WIDTH-2:0], s[REG_WIDTH-1]};
            out_bit = s[REG_WIDTH-1];
         end
         default: begin
            next    = s;
            out_bit = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: load/dump/shift/rotate commands with a valid/ready handshake
// and multi-cycle shifts executed one bit per clock.
module univ_shift_reg
   import shift_reg_pkg::*;
#(
   parameter  int REG_WIDTH = 8,
   localparam int AMT_WIDTH = $clog2(REG_WIDTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [REG_WIDTH-1:0] inbus,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [2:0]           op,
   input  logic [AMT_WIDTH-1:0] amount,
   input  logic                 shiftin,
   output logic [REG_WIDTH-1:0] outbus,
   output logic                 shiftout,
   output logic                 lsb,
   output logic                 msb,
   output logic                 done
);

   state_t                 state_q, state_d;
   op_t                    op_q, op_d;
   op_t                    op_in;
   logic [AMT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [AMT_WIDTH-1:0]   amt_clamped;
   logic [REG_WIDTH-1:0]   storage_q, storage_d;
   logic [REG_WIDTH-1:0]   outbus_d;
   logic                   shiftout_d;
   logic                   done_d;
   logic [REG_WIDTH-1:0]   step_next;
   logic                   step_out;

   assign op_in       = op_t'(op);
   assign amt_clamped = (amount > AMT_WIDTH'(REG_WIDTH)) ? AMT_WIDTH'(REG_WIDTH) : amount;
   assign cmd_ready   = (state_q == ST_IDLE);
   assign lsb         = storage_q[0];
   assign msb         = storage_q[REG_WIDTH-1];

   shift_step #(
      .REG_WIDTH (REG_WIDTH)
   ) u_step (
      .s       (storage_q),
      .op      (op_q),
      .shiftin (shiftin),
      .next    (step_next),
      .out_bit (step_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_NOP;
         cnt_q     <= '0;
         storage_q <= '0;
         outbus    <= '0;
         shiftout  <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         storage_q <= storage_d;
         outbus    <= outbus_d;
         shiftout  <= shiftout_d;
         done      <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      storage_d  = storage_q;
      outbus_d   = outbus;
      shiftout_d = shiftout;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (op_in == OP_LOAD) begin
                  storage_d  = inbus;
                  shiftout_d = 1'b0;
                  done_d     = 1'b1;
               end else if (op_in == OP_DUMP) begin
                  outbus_d = storage_q;
                  done_d   = 1'b1;
               end else if (is_shift_op(op_in)) begin
                  // A zero count completes immediately without entering SHIFT.
                  op_d  = op_in;
                  cnt_d = amt_clamped;
                  if (amt_clamped == '0) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = ST_SHIFT;
                  end
               end
            end
         end
         ST_SHIFT: begin
            storage_d  = step_next;
            shiftout_d = step_out;
            cnt_d      = cnt_q - AMT_WIDTH'(1);
            if (cnt_q == AMT_WIDTH'(1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (REG_WIDTH=8) with hand-computed expectations.
module tb_univ_shift_reg;
   import shift_reg_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] inbus;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] op;
   logic [3:0] amount;
   logic       shiftin;
   logic [7:0] outbus;
   logic       shiftout;
   logic       lsb;
   logic       msb;
   logic       done;

   int n_vec = 0;
   int n_err = 0;

   univ_shift_reg #(.REG_WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inbus     (inbus),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .op        (op),
      .amount    (amount),
      .shiftin   (shiftin),
      .outbus    (outbus),
      .shiftout  (shiftout),
      .lsb       (lsb),
      .msb       (msb),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Presents one command for a single accept edge; returns at the negedge after it.
   task automatic do_cmd(input logic [2:0] o, input logic [3:0] a, input logic [7:0] d,
                         input logic si);
      @(negedge clk);
      op = o; amount = a; inbus = d; shiftin = si; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0; op = OP_NOP;
   endtask

   // Accept-to-done latency in cycles, bounded so a missing done cannot hang the run.
   task automatic wait_done(output int lat);
      int n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      lat = n + 1;
   endtask

   initial begin
      logic [7:0] sar_exp [3] = '{8'hCB, 8'hE5, 8'hF2};
      logic       sar_out [3] = '{1'b0, 1'b1, 1'b1};
      logic [7:0] shr_exp [4] = '{8'h9E, 8'h4F, 8'hA7, 8'h53};
      logic       shr_in  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      int lat;
      int ndone;

      rst_n = 1'b0; inbus = '0; cmd_valid = 1'b0; op = OP_NOP; amount = '0; shiftin = 1'b0;
      #3;
      check("rst_outbus", outbus, 8'h00);
      check("rst_shiftout", shiftout, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ready", cmd_ready, 1'b1);
      check("rst_lsb_msb", {msb, lsb}, 2'b00);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // LOAD then DUMP
      do_cmd(OP_LOAD, 4'd0, 8'hA5, 1'b0);
      check("load_done", done, 1'b1);
      check("load_lsb_msb", {msb, lsb}, 2'b11);
      check("load_storage", dut.storage_q, 8'hA5);
      do_cmd(OP_DUMP, 4'd0, 8'h00, 1'b0);
      check("dump_outbus", outbus, 8'hA5);
      check("dump_done", done, 1'b1);
      @(negedge clk);
      check("dump_done_clr", done, 1'b0);
      check("dump_outbus_hold", outbus, 8'hA5);

      // SAR by 3 on 0x96
      do_cmd(OP_LOAD, 4'd0, 8'h96, 1'b0);
      do_cmd(OP_SAR, 4'd3, 8'h00, 1'b0);
      check("sar_ready0", cmd_ready, 1'b0);
      check("sar_nodone0", done, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("sar_st%0d", i), dut.storage_q, sar_exp[i]);
         check($sformatf("sar_so%0d", i), shiftout, sar_out[i]);
         check($sformatf("sar_rdy%0d", i), cmd_ready, (i == 2) ? 1'b1 : 1'b0);
         check($sformatf("sar_done%0d", i), done, (i == 2) ? 1'b1 : 1'b0);
      end
      @(negedge clk);
      check("sar_done_clr", done, 1'b0);

      // ROL by 8 restores the value
      do_cmd(OP_LOAD, 4'd0, 8'h81, 1'b0);
      do_cmd(OP_ROL, 4'd8, 8'h00, 1'b0);
      wait_done(lat);
      check("rol8_lat", lat, 9);
      check("rol8_storage", dut.storage_q, 8'h81);
      check("rol8_shiftout", shiftout, 1'b1);

      // SHL by 12 clamps to 8
      do_cmd(OP_SHL, 4'd12, 8'h00, 1'b0);
      wait_done(lat);
      check("shl12_lat", lat, 9);
      check("shl12_storage", dut.storage_q, 8'h00);
      check("shl12_shiftout", shiftout, 1'b1);

      // SHR by 0
      do_cmd(OP_LOAD, 4'd0, 8'h3C, 1'b0);
      do_cmd(OP_SHR, 4'd0, 8'h00, 1'b0);
      check("shr0_done", done, 1'b1);
      check("shr0_ready", cmd_ready, 1'b1);
      check("shr0_storage", dut.storage_q, 8'h3C);

      // SHR by 4 with per-step shiftin and a LOAD attempt mid-shift
      do_cmd(OP_SHR, 4'd4, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         shiftin = shr_in[i];
         if (i == 1) begin
            op = OP_LOAD; inbus = 8'hFF; cmd_valid = 1'b1;
            check("busy_ready", cmd_ready, 1'b0);
         end else begin
            cmd_valid = 1'b0; op = OP_NOP;
         end
         @(negedge clk);
         check($sformatf("shr_st%0d", i), dut.storage_q, shr_exp[i]);
      end
      check("shr4_done", done, 1'b1);
      check("shr4_shiftout", shiftout, 1'b1);
      do_cmd(OP_DUMP, 4'd0, 8'h00, 1'b0);
      check("shr4_dump", outbus, 8'h53);

      // ROR by 1 and port taps
      do_cmd(OP_LOAD, 4'd0, 8'h01, 1'b0);
      check("ld01_shiftout", shiftout, 1'b0);
      do_cmd(OP_ROR, 4'd1, 8'h00, 1'b0);
      @(negedge clk);
      check("ror1_done", done, 1'b1);
      check("ror1_lsb_msb", {msb, lsb}, 2'b10);
      check("ror1_shiftout", shiftout, 1'b1);

      // NOP: no change, no done
      do_cmd(OP_LOAD, 4'd0, 8'h5A, 1'b0);
      do_cmd(OP_NOP, 4'd3, 8'hFF, 1'b1);
      check("nop_done", done, 1'b0);
      check("nop_storage", dut.storage_q, 8'h5A);
      check("nop_ready", cmd_ready, 1'b1);

      // Reset during SHR by 5
      do_cmd(OP_LOAD, 4'd0, 8'hF0, 1'b0);
      do_cmd(OP_SHR, 4'd5, 8'h00, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_storage", dut.storage_q, 8'h00);
      check("arst_outbus", outbus, 8'h00);
      check("arst_done", done, 1'b0);
      check("arst_ready", cmd_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("arst_nodone", ndone, 0);
      check("arst_storage_hold", dut.storage_q, 8'h00);
      do_cmd(OP_LOAD, 4'd0, 8'hC3, 1'b0);
      check("post_rst_load", dut.storage_q, 8'hC3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 8, meaning storage and bus width (>=2).
REQ-002 SHALL have localparam AMT_WIDTH = $clog2(REG_WIDTH)+1, meaning shift-amount width (covers 0..REG_WIDTH).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 inbus  in  REG_WIDTH  parallel load data.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 op  in  3  command: 000 NOP, 001 LOAD, 010 DUMP, 011 SHR, 100 SAR, 101 SHL, 110 ROR, 111 ROL.
REQ-008 amount  in  AMT_WIDTH  shift count for shift/rotate ops.
REQ-009 shiftin  in  1  fill bit for SHR/SHL.
REQ-010 outbus  out  REG_WIDTH  registered dump output.
REQ-011 shiftout  out  1  last bit shifted/rotated out.
REQ-012 lsb, msb  out  1 each  combinational storage[0], storage[REG_WIDTH-1].
REQ-013 done  out  1  one-cycle pulse at completion of any accepted non-NOP command.

Function
REQ-014 SHALL be a clocked FSM with states IDLE and SHIFT; cmd_ready = 1 only in IDLE.
REQ-015 Command accepted on rising clk when cmd_valid && cmd_ready; cmd_valid while busy ignored, not queued.
REQ-016 LOAD: storage <= inbus, shiftout <= 0 at accept edge; done pulses next cycle.
REQ-017 DUMP: outbus <= storage at accept edge; done pulses next cycle; outbus holds otherwise.
REQ-018 Shift ops: amount latched at accept, clamped to REG_WIDTH; counter = clamped amount; go to SHIFT if nonzero.
REQ-019 amount = 0: storage unchanged, stay IDLE, done pulses next cycle.
REQ-020 In SHIFT, one bit per cycle; counter decrements; return to IDLE and pulse done the cycle after the last step.
REQ-021 Step rules: SHR {shiftin, s[W-1:1]}, out s[0]; SAR {s[W-1], s[W-1:1]}, out s[0]; SHL {s[W-2:0], shiftin}, out s[W-1]; ROR {s[0], s[W-1:1]}, out s[0]; ROL {s[W-2:0], s[W-1]}, out s[W-1].
REQ-022 shiftout updates on every step with the step's out bit; holds otherwise.
REQ-023 shiftin sampled each step (not latched at accept).
REQ-024 NOP accepted, no state change, no done.
REQ-025 Latency: LOAD/DUMP/amount-0 = 1 cycle to done; shift by N = N+1 cycles accept-to-done.

Reset
REQ-026 rst_n low SHALL asynchronously force storage 0, outbus 0, shiftout 0, done 0, counter 0, state IDLE.
REQ-027 Reset mid-SHIFT SHALL abort the operation with no done pulse; cmd_ready = 1 on first clk after release.

Structure
REQ-028 Op encoding enum and FSM state enum SHALL live in shared package shift_reg_pkg.
REQ-029 Single-step next-value/out-bit logic SHALL be sub-module shift_step (combinational, parametrised REG_WIDTH).

Verification (REG_WIDTH=8)
REQ-030 LOAD 0xA5, then DUMP -> outbus 0xA5 on the edge after DUMP accept; done pulses after each command.
REQ-031 Storage 0x96, SAR amount 3 -> cmd_ready low 3 cycles, storage 0xCB, 0xE5, 0xF2; shiftout 0,1,1; done 1 cycle after.
REQ-032 Storage 0x81, ROL amount 8 -> storage 0x81 after 8 steps; SHL amount 12, shiftin 0 -> clamped to 8, storage 0x00, done after 9 cycles.
REQ-033 SHR amount 0 on 0x3C -> storage 0x3C, done next cycle; LOAD issued during a shift ignored, storage unaffected.
REQ-034 rst_n asserted at step 2 of SHR amount 5 -> storage 0, outbus 0, no done, cmd_ready 1 after release.
